// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence transmitter and the bit-serial detectors.
// Holds the transmitter state encoding and the reference 1011 pattern.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        GAP   = 2'd3
    } seq_tx_state_t;

    localparam logic [3:0] SEQ_PAT_1011 = 4'b1011;
    localparam int         SEQ_PAT_LEN  = 4;

    // GAP_CYCLES is bounded to 0..15, so the dwell counter never needs more than 4 bits.
    localparam int         SEQ_GAP_W    = 4;

endpackage

// File: rtl/seq_tx_gap_cnt.sv
// Loadable down-counter for the inter-word idle dwell.
// tc_o flags the final dwell cycle (count of one).
module seq_tx_gap_cnt
    import seq_pkg::*;
#(
    parameter int W = SEQ_GAP_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/seq_tx_serializer.sv
// MSB-first serial word transmitter with per-word length and an optional idle gap.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after each word.
module seq_tx_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LEN_W      = $clog2(WIDTH + 1),
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for a word, in_ready high
    // SHIFT | one data bit per cycle, MSB of the length field first
    // PAR   | single even-parity bit (parity build only)
    // GAP   | out_valid low for GAP_CYCLES cycles

    localparam logic [LEN_W-1:0]     WIDTH_L = LEN_W'(WIDTH);
    localparam logic [SEQ_GAP_W-1:0] GAP_LD  = SEQ_GAP_W'(GAP_CYCLES);
    localparam bit                   GAP_EN  = (GAP_CYCLES > 0);
`ifdef SEQ_TX_PARITY_EN
    localparam bit                   PAR_EN  = 1'b1;
`else
    localparam bit                   PAR_EN  = 1'b0;
`endif

    seq_tx_state_t    state_q;
    logic [WIDTH-1:0] sh_q;
    logic [LEN_W-1:0] cnt_q;
    logic             out_bit_q;
    logic             out_valid_q;
    logic             out_last_q;
`ifdef SEQ_TX_PARITY_EN
    logic             par_q;
`endif

    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] aligned;
    logic             gap_load;
    logic             gap_tc;

    always_comb begin
        eff_len = ((in_len == '0) || (in_len > WIDTH_L)) ? WIDTH_L : in_len;
        aligned = in_data << (WIDTH_L - eff_len);
    end

`ifdef SEQ_TX_PARITY_EN
    assign gap_load = (state_q == PAR);
`else
    assign gap_load = (state_q == SHIFT) && (cnt_q == LEN_W'(1));
`endif

    seq_tx_gap_cnt #(.W(SEQ_GAP_W)) u_gap_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (gap_load),
        .load_val_i (GAP_LD),
        .en_i       (state_q == GAP),
        .tc_o       (gap_tc)
    );

    // The first bit is registered on the accepting edge; sh_q then holds only the
    // bits still to come and cnt_q counts the bit on the wire plus those remaining.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q     <= SHIFT;
                        sh_q        <= aligned << 1;
                        cnt_q       <= eff_len;
                        out_bit_q   <= aligned[WIDTH-1];
                        out_valid_q <= 1'b1;
                        out_last_q  <= !PAR_EN && (eff_len == LEN_W'(1));
`ifdef SEQ_TX_PARITY_EN
                        par_q       <= aligned[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    if (cnt_q > LEN_W'(1)) begin
                        sh_q       <= sh_q << 1;
                        cnt_q      <= cnt_q - 1'b1;
                        out_bit_q  <= sh_q[WIDTH-1];
                        out_last_q <= !PAR_EN && (cnt_q == LEN_W'(2));
`ifdef SEQ_TX_PARITY_EN
                        par_q      <= par_q ^ sh_q[WIDTH-1];
`endif
                    end else begin
                        cnt_q <= '0;
`ifdef SEQ_TX_PARITY_EN
                        state_q     <= PAR;
                        out_bit_q   <= par_q;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b1;
`else
                        state_q     <= GAP_EN ? GAP : IDLE;
                        out_bit_q   <= 1'b0;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
`endif
                    end
                end
                PAR: begin
                    state_q     <= GAP_EN ? GAP : IDLE;
                    out_bit_q   <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
                GAP: begin
                    if (gap_tc) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_seq_tx_serializer.sv
// Scoreboard bench for seq_tx_serializer: one instance without gap, one with a 3-cycle gap.
// Expected bit streams are hand-derived per vector; parity bits are appended when SEQ_TX_PARITY_EN is set.
module tb_seq_tx_serializer;
    import seq_pkg::*;

    typedef struct {
        logic b;
        logic last;
        int   cyc;
    } exp_t;

`ifdef SEQ_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int G1 = 3;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic [1:0] in_valid = 2'b00;
    logic [7:0] in_data [2];
    logic [3:0] in_len  [2];
    wire  [1:0] in_ready, out_bit, out_valid, out_last, busy;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sbq [2][$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    seq_tx_serializer #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_len(in_len[0]),
        .out_bit(out_bit[0]), .out_valid(out_valid[0]),
        .out_last(out_last[0]), .busy(busy[0])
    );

    seq_tx_serializer #(.WIDTH(8), .GAP_CYCLES(G1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_len(in_len[1]),
        .out_bit(out_bit[1]), .out_valid(out_valid[1]),
        .out_last(out_last[1]), .busy(busy[1])
    );

    // Monitor: every valid output bit must match the head of that instance's queue.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (out_valid[d] === 1'b1) begin
                total++;
                if (sbq[d].size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_bit dut%0d cyc=%0d got bit=%b last=%b, none expected",
                             d, cyc, out_bit[d], out_last[d]);
                end else begin
                    mon_e = sbq[d].pop_front();
                    if (out_bit[d] !== mon_e.b || out_last[d] !== mon_e.last || cyc != mon_e.cyc) begin
                        bad++;
                        $display("FAIL stream dut%0d got bit=%b last=%b cyc=%0d expected bit=%b last=%b cyc=%0d",
                                 d, out_bit[d], out_last[d], cyc, mon_e.b, mon_e.last, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge (cyc == acc).
    task automatic send(input int d, input logic [7:0] data, input logic [3:0] len,
                        input int n, input logic [7:0] bits, input logic pbit,
                        input bit keep, output int acc);
        int   w;
        exp_t e;
        w = 0;
        in_data[d]  = data;
        in_len[d]   = len;
        in_valid[d] = 1'b1;
        while (in_ready[d] !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (in_ready[d] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout dut%0d got in_ready=%b expected 1", d, in_ready[d]);
            in_valid[d] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        for (int i = 0; i < n; i++) begin
            e.b    = bits[n-1-i];
            e.last = (PB == 0) && (i == n - 1);
            e.cyc  = acc + i;
            sbq[d].push_back(e);
        end
        if (PB != 0) begin
            e.b    = pbit;
            e.last = 1'b1;
            e.cyc  = acc + n;
            sbq[d].push_back(e);
        end
        @(negedge clk);
        if (!keep) in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int w;
        w = 0;
        while (busy[d] !== 1'b0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (busy[d] !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout dut%0d got busy=%b expected 0", d, busy[d]);
        end
        @(negedge clk);
    endtask

    initial begin
        int a, a2, t0;
        in_data[0] = '0; in_data[1] = '0;
        in_len[0]  = '0; in_len[1]  = '0;

        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd3);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_out_last_bit", 32'({out_last, out_bit}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic 1011 word, accepted on the first edge, in_ready low for the word.
        t0 = cyc;
        send(0, 8'h0B, 4'd4, 4, {4'b0000, SEQ_PAT_1011}, 1'b1, 1'b0, a);
        chk("accept_first_edge", a, t0 + 1);
        for (int i = 0; i < 4 + PB; i++) begin
            chk("ready_low_during_word", 32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        chk("ready_after_word", 32'(in_ready[0]), 32'd1);
        wait_idle(0);

        // Loopback pattern, clamp cases and the single-bit extreme.
        send(0, 8'hBB, 4'd8,  8, 8'hBB,         1'b0, 1'b0, a); wait_idle(0);
        send(0, 8'hA5, 4'd0,  8, 8'hA5,         1'b0, 1'b0, a); wait_idle(0);
        send(0, 8'h01, 4'd1,  1, 8'h01,         1'b1, 1'b0, a); wait_idle(0);
        send(0, 8'h09, 4'd4,  4, 8'h09,         1'b0, 1'b0, a); wait_idle(0);
        send(0, 8'h3C, 4'd12, 8, 8'h3C,         1'b0, 1'b0, a); wait_idle(0);

        // Back-to-back without gap: only the one-cycle IDLE bubble separates words.
        send(0, 8'hF5, 4'd3, 3, 8'b0000_0101, 1'b0, 1'b1, a);
        send(0, 8'hFE, 4'd2, 2, 8'b0000_0010, 1'b1, 1'b0, a2);
        chk("b2b_spacing_nogap", a2 - a, 3 + PB + 1);
        wait_idle(0);

        // Back-to-back with a 3-cycle gap; word 2 is presented while word 1 is busy.
        send(1, 8'h0B, 4'd4, 4, 8'h0B,        1'b1, 1'b1, a);
        send(1, 8'h06, 4'd3, 3, 8'b0000_0110, 1'b0, 1'b0, a2);
        chk("b2b_spacing_gap", a2 - a, 4 + PB + G1 + 1);
        wait_idle(1);

        // Asynchronous reset during bit 2 of an all-ones word.
        send(0, 8'hFF, 4'd8, 8, 8'hFF, 1'b0, 1'b0, a);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid[0]), 32'd0);
        chk("midreset_in_ready", 32'(in_ready[0]), 32'd1);
        chk("midreset_busy", 32'(busy[0]), 32'd0);
        sbq[0].delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(0, 8'h0B, 4'd4, 4, 8'h0B, 1'b1, 1'b0, a);
        wait_idle(0);

        repeat (5) @(negedge clk);
        chk("leftover_expected_dut0", sbq[0].size(), 0);
        chk("leftover_expected_dut1", sbq[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_tx_serializer.md
Name: seq_tx_serializer

Overview:
- Serial pattern transmitter. Takes parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- Produces the single-bit stream consumed by the team's serial sequence detectors, e.g. the 1011 detector. It is the stimulus/transmit end of that bit-serial interface.
- Supports a per-word bit length and a configurable idle gap between words.

Parameters:
- WIDTH, 8, maximum word length in bits (>=2).
- LEN_W, $clog2(WIDTH+1), width of the length field.
- GAP_CYCLES, 0, idle cycles (out_valid=0) inserted after each word; range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  word offered.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word; the low in_len bits are transmitted.
- in_len  input  LEN_W  number of bits to send.
- out_bit  output  1  serial data; only meaningful when out_valid=1.
- out_valid  output  1  out_bit carries a stream bit this cycle.
- out_last  output  1  high with the final bit of a word (the parity bit when parity is enabled).
- busy  output  1  any state other than IDLE.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Asynchronous active-low reset; release is synchronised externally.
  - While reset_n=0: state=IDLE, shift register=0, bit counter=0, out_bit=0, out_valid=0, out_last=0, busy=0, in_ready=1.
- Outputs:
  - out_bit, out_valid and out_last are registered.
  - in_ready = (state==IDLE), combinational from state.
  - busy = (state!=IDLE).
- Accept:
  - A transfer occurs on a rising edge with in_valid & in_ready.
  - Effective length L = in_len, clamped to WIDTH when in_len==0 or in_len>WIDTH.
  - in_data is left-aligned into the shift register, so bit in_data[L-1] goes first.
  - Bit counter loads L. State moves to SHIFT.
- Latency: the first bit appears on out_bit/out_valid in the cycle after the accepting edge.
- States:
  - IDLE: out_valid=0, out_bit=0, out_last=0. A transfer moves to SHIFT.
  - SHIFT:
    - Each cycle: drive the shift register MSB with out_valid=1, shift left, decrement the counter.
    - On the bit where counter==1: assert out_last, unless parity is enabled.
    - Then go to PAR if parity is enabled; else to GAP if GAP_CYCLES>0; else to IDLE.
  - PAR (parity build only): one cycle, with out_bit=parity, out_valid=1, out_last=1. Then go to GAP or IDLE.
  - GAP: out_valid=0 for exactly GAP_CYCLES cycles, then IDLE.
- Throughput:
  - There is no acceptance during a word. in_data/in_len changes while busy are ignored.
  - Minimum spacing between first bits of consecutive words = L + GAP_CYCLES + 1 cycles; IDLE is always a one-cycle bubble.
- Bit stream: the stream is exactly the L bits of the word, MSB of the field first. No framing or start bits are added.
- Boundary conditions:
  - L=1 gives a one-cycle SHIFT with out_last=1.
  - L=WIDTH transmits the whole in_data.
  - in_valid=1 held in IDLE is accepted on the first edge.
- Reset mid-word: outputs drop to their reset values immediately (asynchronous). The partial word is discarded and is not resumed.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the L transmitted data bits) is sent in PAR, right after the last data bit.
  - out_last moves to the parity bit.
  - Word duration becomes L+1.
- Undefined: the PAR state and parity logic are absent, and out_last accompanies the last data bit.

Decomposition:
- Shared package seq_pkg:
  - State encoding typedef seq_tx_state_t: IDLE, SHIFT, PAR, GAP.
  - Shared pattern constant SEQ_PAT_1011 = 4'b1011 with SEQ_PAT_LEN = 4, reused by the detectors and the bench.
- One natural sub-module: seq_tx_gap_cnt, a loadable down-counter used for the GAP dwell.
- The shift path and FSM stay in the top module.

Test Plan:
- Basic 1011: WIDTH=8, in_data=8'h0B, in_len=4, GAP=0 -> out_bit 1,0,1,1 on cycles 1-4 after accept; out_valid high for 4 cycles; out_last on cycle 4; in_ready low for cycles 1-4.
- Loopback: feed 8'hB_B (in_len=8) into the 1011 detector -> seq_seen pulses after bits 4 and 8 (overlap through the SEQ_1011 state); no other pulses.
- Clamp and extremes: in_len=0 and data 8'hA5 -> 8 bits 1,0,1,0,0,1,0,1; in_len=1 and data 8'h01 -> single bit 1 with out_last set.
- Gap/back-to-back: GAP_CYCLES=3, two words held valid -> 3 cycles of out_valid=0 plus a 1-cycle IDLE bubble between words; data changed while busy has no effect.
- Reset mid-word: assert reset_n=0 asynchronously during bit 2 of 8'hFF -> out_valid=0 and in_ready=1 without a clock edge; after release, the next word transmits from its first bit.
- Parity (SEQ_TX_PARITY_EN): 4'b1011 with L=4 -> stream 1,0,1,1,1, out_last on the 5th bit; 4'b1001 -> parity bit 0.
